// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: detects hazards the forwarding path cannot cover, freezes the pipe
// for SRAM accesses, flushes on taken branches and keeps saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int unsigned MEM_LATENCY = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_EN,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [3:0]       MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             mem_req,
  input  logic             branch_taken,
  output logic             freeze_all,
  output logic             freeze_front,
  output logic             bubble_EXE,
  output logic             flush,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wait counter holds MEM_LATENCY-1; never narrower than 2 bits.
  localparam int unsigned WAIT_W = (MEM_LATENCY < 4) ? 2 : $clog2(MEM_LATENCY);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              match_exe, match_mem, hazard;

  // Source-register comparisons are literal; R0 is not special.
  always_comb begin
    match_exe = (src1 == EXE_Dest) || (two_src && (src2 == EXE_Dest));
    match_mem = (src1 == MEM_Dest) || (two_src && (src2 == MEM_Dest));
    if (forward_EN) begin
      hazard = EXE_WB_EN && EXE_MEM_R_EN && match_exe;
    end else begin
      hazard = (EXE_WB_EN && match_exe) || (MEM_WB_EN && match_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and combinational controls; freeze_all outranks flush, flush outranks the hazard stall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freeze_all   = 1'b0;
    freeze_front = 1'b0;
    bubble_EXE   = 1'b0;
    flush        = 1'b0;
    mem_busy     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req) begin
          freeze_all = 1'b1;
          state_d    = WAIT;
          cnt_d      = WAIT_W'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        mem_busy = 1'b1;
        if (cnt_q != '0) begin
          freeze_all = 1'b1;
          cnt_d      = cnt_q - WAIT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    flush        = !freeze_all && branch_taken;
    freeze_front = !freeze_all && !branch_taken && hazard;
    bubble_EXE   = freeze_front;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze_all || freeze_front) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: a behavioural model predicts every cycle's controls
// and counters; a negedge monitor pops and compares.
module tb_hazard_stall_controller;

  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_EN, two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN, mem_req, branch_taken;
  logic [3:0] src1, src2, EXE_Dest, MEM_Dest;

  logic        freeze_all, freeze_front, bubble_EXE, flush, mem_busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_freeze_all, s_freeze_front, s_bubble_EXE, s_flush, s_mem_busy;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MEM_LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .forward_EN(forward_EN), .src1(src1), .src2(src2), .two_src(two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze_all(freeze_all), .freeze_front(freeze_front), .bubble_EXE(bubble_EXE),
    .flush(flush), .mem_busy(mem_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_stall_controller #(.MEM_LATENCY(LAT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .forward_EN(forward_EN), .src1(src1), .src2(src2), .two_src(two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze_all(s_freeze_all), .freeze_front(s_freeze_front), .bubble_EXE(s_bubble_EXE),
    .flush(s_flush), .mem_busy(s_mem_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    bit fa, ff, fl, mb;
    int unsigned sc, fc, sc2, fc2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: WAIT cycles still to come for the current access (0 = running), raw event totals.
  int unsigned busy_left = 0;
  longint      raw_stall = 0;
  longint      raw_flush = 0;

  function automatic int unsigned sat(input longint v, input int unsigned w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? int'(mx) : int'(v);
  endfunction

  function automatic bit reads(input int r);
    return (int'(src1) == r) || (two_src && int'(src2) == r);
  endfunction

  // Predict this cycle's response from the current inputs, then advance the model one clock.
  task automatic tick();
    exp_t e;
    bit   frozen, hz;
    frozen = (busy_left == 0 && mem_req) || (busy_left > 1);
    if (forward_EN) hz = EXE_WB_EN && EXE_MEM_R_EN && reads(int'(EXE_Dest));
    else            hz = (EXE_WB_EN && reads(int'(EXE_Dest))) || (MEM_WB_EN && reads(int'(MEM_Dest)));
    e.fa  = frozen;
    e.ff  = !frozen && !branch_taken && hz;
    e.fl  = !frozen && branch_taken;
    e.mb  = busy_left > 0;
    e.sc  = sat(raw_stall, 16);
    e.fc  = sat(raw_flush, 16);
    e.sc2 = sat(raw_stall, 2);
    e.fc2 = sat(raw_flush, 2);
    sb.push_back(e);
    if (rst) begin
      busy_left = 0;
      raw_stall = 0;
      raw_flush = 0;
    end else begin
      if (busy_left == 0) busy_left = mem_req ? LAT : 0;
      else                busy_left = busy_left - 1;
      if (e.fa || e.ff) raw_stall++;
      if (e.fl)         raw_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("freeze_all",   32'(freeze_all),   32'(e.fa));
      chk("freeze_front", 32'(freeze_front), 32'(e.ff));
      chk("bubble_EXE",   32'(bubble_EXE),   32'(e.ff));
      chk("flush",        32'(flush),        32'(e.fl));
      chk("mem_busy",     32'(mem_busy),     32'(e.mb));
      chk("stall_cnt",    32'(stall_cnt),    e.sc);
      chk("flush_cnt",    32'(flush_cnt),    e.fc);
      chk("stall_cnt_w2", 32'(s_stall_cnt),  e.sc2);
      chk("flush_cnt_w2", 32'(s_flush_cnt),  e.fc2);
    end
  end

  task automatic idle();
    rst = 0; forward_EN = 1; two_src = 0; EXE_WB_EN = 0; EXE_MEM_R_EN = 0; MEM_WB_EN = 0;
    mem_req = 0; branch_taken = 0; src1 = 4'd1; src2 = 4'd2; EXE_Dest = 4'd7; MEM_Dest = 4'd8;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    tick(); tick();
    idle();
    tick();

    // Load-use with forwarding on.
    EXE_Dest = 4'd3; EXE_WB_EN = 1; EXE_MEM_R_EN = 1; src1 = 4'd3;
    tick();
    idle(); tick(); tick();

    // No forwarding: dependency on MEM stage through src2, then src2 unused.
    forward_EN = 0; MEM_Dest = 4'd5; MEM_WB_EN = 1; src2 = 4'd5; two_src = 1;
    tick();
    two_src = 0;
    tick();
    idle(); tick();

    // Single-cycle SRAM access pulse.
    rst = 1; tick(); idle();
    mem_req = 1; tick();
    mem_req = 0; repeat (5) tick();

    // Branch and load-use in the same cycle.
    rst = 1; tick(); idle();
    EXE_Dest = 4'd3; EXE_WB_EN = 1; EXE_MEM_R_EN = 1; src1 = 4'd3; branch_taken = 1;
    tick();
    idle(); tick();

    // Reset during the second WAIT cycle with mem_req held.
    mem_req = 1; tick(); tick();
    rst = 1; tick();
    rst = 0; mem_req = 0; tick(); tick();

    // Saturation of the narrow counters, then back-to-back accesses.
    rst = 1; tick(); idle();
    EXE_Dest = 4'd3; EXE_WB_EN = 1; EXE_MEM_R_EN = 1; src1 = 4'd3;
    repeat (5) tick();
    idle();
    mem_req = 1; repeat (12) tick();
    idle(); tick();

    // Random traffic; small register range to make collisions frequent.
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      forward_EN   = 1'($urandom_range(0, 1));
      two_src      = 1'($urandom_range(0, 1));
      EXE_WB_EN    = 1'($urandom_range(0, 1));
      EXE_MEM_R_EN = 1'($urandom_range(0, 1));
      MEM_WB_EN    = 1'($urandom_range(0, 1));
      mem_req      = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      src1         = 4'($urandom_range(0, 3));
      src2         = 4'($urandom_range(0, 3));
      EXE_Dest     = 4'($urandom_range(0, 3));
      MEM_Dest     = 4'($urandom_range(0, 3));
      if (i % 100 == 99) src1 = 4'($urandom_range(0, 15));
      tick();
    end
    idle();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
